countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counting timer with one-shot and periodic modes, a single-cycle expiry pulse and a sticky interrupt flag with acknowledge. It counts down where the existing up-counter counts up. It sits beside that counter in the timing subsystem and supplies timeouts and periodic ticks to control logic. A three-state FSM (IDLE/RUN/DONE) governs counting.

## Interface
- WIDTH, 16, width of count and reload value
- PRESC_WIDTH, 8, width of prescaler divide value (used only with prescaler compiled in)

- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- load_i  input  1  write load_value_i into reload register and count
- load_value_i  input  WIDTH  reload value
- start_i  input  1  start countdown from reload register
- stop_i  input  1  abort countdown, return to IDLE
- periodic_i  input  1  1: auto-reload on expiry; 0: one-shot
- presc_i  input  PRESC_WIDTH  tick divider, tick every presc_i+1 cycles
- irq_ack_i  input  1  clear irq_o
- count_o  output  WIDTH  current count (registered)
- busy_o  output  1  high while in RUN
- expired_o  output  1  one-cycle pulse on expiry
- irq_o  output  1  sticky expiry flag

Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.

## Operation
- Reset values: state IDLE, reload 0, count_o 0, busy_o 0, expired_o 0, irq_o 0; prescaler counter 0.
- Per-cycle priority: rst_i > stop_i > load_i > start_i > tick.
- stop_i, any state: go to IDLE. count_o holds its value. No expiry.
- load_i in IDLE or DONE: reload ← load_value_i and count ← load_value_i. State is unchanged.
- load_i in RUN with nonzero value: reload and count ← load_value_i, stay in RUN, countdown restarts.
- load_i in RUN with zero value: count ← 0, go to IDLE, no expiry.
- start_i in IDLE or DONE with reload ≠ 0: count ← reload, go to RUN.
- start_i with reload = 0: ignored.
- start_i in RUN: ignored; the countdown does not restart.
- On a tick in RUN with count > 1: count decrements by 1.
- On a tick in RUN with count = 1: expiry. expired_o is high the next cycle and irq_o is set.
  - periodic_i = 1: count ← reload, stay in RUN.
  - periodic_i = 0: count ← 0, go to DONE.
- periodic_i is sampled at the expiring tick only.
- irq_o is set on expiry and cleared by irq_ack_i. If set and clear coincide, set wins.
- Arithmetic is unsigned, WIDTH bits. Count never wraps below 0.

## Timing
- All outputs are registered.
- If start_i is sampled at edge E0 with reload N, count_o = N after E0. It reads N-1 after E1, and expiry is registered at EN. expired_o and irq_o are high in the cycle after EN, so expiry comes N cycles after the start edge.
- Periodic mode: expired_o pulses every N cycles. The pulse is never wider than 1 cycle, including when N = 1.
- busy_o is high the cycle after the start edge. It goes low the cycle after expiry (one-shot), stop, or load 0.

## Configuration
- COUNTDOWN_TIMER_PRESCALER_EN defined: a prescaler generates the tick once every presc_i+1 cycles.
  - The prescaler counter resets to 0 on start, load, stop and expiry reload, so the first tick is presc_i+1 cycles after start.
  - Expiry occurs N·(presc_i+1) cycles after the start edge.
  - presc_i is sampled each cycle; a change takes effect at the next prescaler wrap.
- Undefined: tick every cycle in RUN and presc_i is ignored. The port remains present.

## Structure
- countdown_timer_pkg: state enum (IDLE, RUN, DONE) typedef.
- Sub-module tick_prescaler (PRESC_WIDTH parameter; clk_i, rst_i, clear_i, enable_i, div_i, tick_o). It is instantiated only under COUNTDOWN_TIMER_PRESCALER_EN.

## Test plan
- Reset, then load 5 and start: count_o reads 5,4,3,2,1,0. expired_o is high exactly 5 cycles after the start edge. State ends in DONE, busy_o 0, irq_o 1.
- periodic_i = 1, reload 3, run 10 cycles: expired_o pulses at cycles 3, 6 and 9. Each pulse is 1 cycle wide and busy_o stays 1.
- stop_i at count 2: count_o holds 2 and no expiry follows. A later start reloads and expires N cycles later.
- Coincident events:
  - load 7 and start in the same cycle: load wins; count 7, still IDLE.
  - irq_ack_i on the same cycle as an expiry: irq_o stays 1.
- start with reload 0 is ignored (busy_o 0). Load 0 in RUN goes to IDLE with no expired_o.
- rst_i mid-run: all outputs read reset values the next cycle. With COUNTDOWN_TIMER_PRESCALER_EN, presc_i = 2 and reload 4, expiry comes 12 cycles after start.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizes for the countdown timer.
package countdown_timer_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_PRESC_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master drives controls, slave is the timer.
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
);
    logic                   load_i;
    logic [WIDTH-1:0]       load_value_i;
    logic                   start_i;
    logic                   stop_i;
    logic                   periodic_i;
    logic [PRESC_WIDTH-1:0] presc_i;
    logic                   irq_ack_i;
    logic [WIDTH-1:0]       count_o;
    logic                   busy_o;
    logic                   expired_o;
    logic                   irq_o;

    modport master (
        output load_i, load_value_i, start_i, stop_i, periodic_i, presc_i, irq_ack_i,
        input  count_o, busy_o, expired_o, irq_o
    );

    modport slave (
        input  load_i, load_value_i, start_i, stop_i, periodic_i, presc_i, irq_ack_i,
        output count_o, busy_o, expired_o, irq_o
    );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Tick divider: tick_o once every div_i+1 enabled cycles; the divide value is
// captured on clear and at each wrap, so a change lands at the next wrap.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic [PRESC_WIDTH-1:0] div_i,
    output logic                   tick_o
);
    logic [PRESC_WIDTH-1:0] cnt_q;
    logic [PRESC_WIDTH-1:0] div_q;
    logic                   wrap;

    assign wrap   = (cnt_q == div_q);
    assign tick_o = enable_i && wrap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            div_q <= div_i;
        end else if (enable_i) begin
            if (wrap) begin
                cnt_q <= '0;
                div_q <= div_i;
            end else begin
                cnt_q <= cnt_q + PRESC_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic modes, expiry pulse and sticky irq.
// Define COUNTDOWN_TIMER_PRESCALER_EN to divide the count tick by presc_i+1.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    countdown_timer_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, irq_q;
    logic             expire_d;
    logic             presc_clear;
    logic             tick;
    logic             running;
    logic             reload_nz;
    logic             load_nz;
    logic             cnt_one;
    logic             busy;

    assign running   = (state_q == ST_RUN);
    assign reload_nz = (reload_q != '0);
    assign load_nz   = (bus.load_value_i != '0);
    assign cnt_one   = (count_q == WIDTH'(1));

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    tick_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (presc_clear),
        .enable_i(running),
        .div_i   (bus.presc_i),
        .tick_o  (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^{bus.presc_i, presc_clear};
    assign tick         = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Priority: stop > load > start > tick; start in RUN falls through to tick.
    always_comb begin
        state_d = state_q;
        if (bus.stop_i) begin
            state_d = ST_IDLE;
        end else if (bus.load_i) begin
            if (running && !load_nz) state_d = ST_IDLE;
        end else if (bus.start_i && !running && reload_nz) begin
            state_d = ST_RUN;
        end else if (running && tick && cnt_one) begin
            state_d = bus.periodic_i ? ST_RUN : ST_DONE;
        end
    end

    always_comb begin
        count_d     = count_q;
        reload_d    = reload_q;
        expire_d    = 1'b0;
        presc_clear = 1'b0;
        busy        = running;
        if (bus.stop_i) begin
            presc_clear = 1'b1;
        end else if (bus.load_i) begin
            reload_d    = bus.load_value_i;
            count_d     = bus.load_value_i;
            presc_clear = 1'b1;
        end else if (bus.start_i && !running && reload_nz) begin
            count_d     = reload_q;
            presc_clear = 1'b1;
        end else if (running && tick) begin
            if (cnt_one) begin
                expire_d    = 1'b1;
                count_d     = bus.periodic_i ? reload_q : '0;
                presc_clear = 1'b1;
            end else if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expire_d;
            if (expire_d)           irq_q <= 1'b1;
            else if (bus.irq_ack_i) irq_q <= 1'b0;
        end
    end

    assign bus.count_o   = count_q;
    assign bus.busy_o    = busy;
    assign bus.expired_o = expired_q;
    assign bus.irq_o     = irq_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer: per-cycle table plus an expiry-latency sequence.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(16), .PRESC_WIDTH(8)) bus ();

    countdown_timer #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic        rst, load;
        logic [15:0] val;
        logic        start, stop, per, ack;
        logic [15:0] cnt;
        logic        busy, exp, irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, input logic ld, input logic [15:0] val,
                              input logic st, input logic sp, input logic per, input logic ack,
                              input logic [15:0] cnt, input logic b, input logic e, input logic i);
        vec_t t;
        t.rst = r; t.load = ld; t.val = val; t.start = st; t.stop = sp; t.per = per; t.ack = ack;
        t.cnt = cnt; t.busy = b; t.exp = e; t.irq = i;
        tbl.push_back(t);
    endfunction

    task automatic cyc(input logic r, input logic ld, input logic [15:0] val,
                       input logic st, input logic sp, input logic per, input logic ack);
        @(negedge clk);
        rst = r; bus.load_i = ld; bus.load_value_i = val; bus.start_i = st;
        bus.stop_i = sp; bus.periodic_i = per; bus.irq_ack_i = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int exp_lat;
        rst = 1'b1;
        bus.load_i = 0; bus.load_value_i = 0; bus.start_i = 0; bus.stop_i = 0;
        bus.periodic_i = 0; bus.presc_i = 0; bus.irq_ack_i = 0;

        //  rst ld val st sp per ack | cnt b e i
        v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // one-shot 5
        v(0, 1, 5, 0, 0, 0, 0,   5, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0,   5, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
        // periodic 3, pulses every 3 cycles; ack coinciding with expiry loses
        v(0, 1, 3, 0, 0, 1, 0,   3, 0, 0, 0);
        v(0, 0, 0, 1, 0, 1, 0,   3, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0,   2, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0,   3, 1, 1, 1);
        v(0, 0, 0, 0, 0, 1, 1,   2, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0,   3, 1, 1, 1);
        v(0, 0, 0, 0, 0, 1, 0,   2, 1, 0, 1);
        v(0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1);
        v(0, 0, 0, 0, 0, 1, 1,   3, 1, 1, 1);
        v(0, 0, 0, 0, 0, 1, 0,   2, 1, 0, 1);
        // stop at 2 holds, no expiry; restart reloads
        v(0, 0, 0, 0, 1, 1, 0,   2, 0, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1);
        v(0, 0, 0, 1, 0, 0, 0,   3, 1, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1);
        v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0);
        // load+start together: load wins
        v(0, 1, 7, 1, 0, 0, 0,   7, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0);
        // start with reload 0 ignored
        v(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // load 0 in RUN -> IDLE, no expiry
        v(0, 1, 4, 0, 0, 0, 0,   4, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0,   4, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // start in RUN ignored, nonzero load in RUN restarts
        v(0, 1, 6, 0, 0, 0, 0,   6, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0,   6, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0,   4, 1, 0, 0);
        v(0, 1, 2, 0, 0, 0, 0,   2, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1);
        // reset mid-run
        v(0, 1, 3, 0, 0, 0, 0,   3, 0, 0, 1);
        v(0, 0, 0, 1, 0, 0, 0,   3, 1, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 1);
        v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].load, tbl[i].val, tbl[i].start, tbl[i].stop, tbl[i].per, tbl[i].ack);
            chk("count",   i, bus.count_o,          tbl[i].cnt);
            chk("busy",    i, 16'(bus.busy_o),      16'(tbl[i].busy));
            chk("expired", i, 16'(bus.expired_o),   16'(tbl[i].exp));
            chk("irq",     i, 16'(bus.irq_o),       16'(tbl[i].irq));
        end

        // Expiry latency with presc_i = 2, reload 4
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
        exp_lat = 12;
`else
        exp_lat = 4;
`endif
        bus.presc_i = 8'd2;
        cyc(0, 1, 4, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("lat_busy", 0, 16'(bus.busy_o), 16'd1);
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (k == 2) begin
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
                chk("lat_cnt2", k, bus.count_o, 16'd4);
`else
                chk("lat_cnt2", k, bus.count_o, 16'd2);
`endif
            end
            if (bus.expired_o && first == 0) first = k;
        end
        chk("lat_expiry", 0, 16'(first), 16'(exp_lat));
        chk("lat_irq", 0, 16'(bus.irq_o), 16'd1);
        chk("lat_busy_end", 0, 16'(bus.busy_o), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
